// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron input loader.
//
// Contents:
//   - default neuron geometry (fan-in and Q-format split of data and weights)
//   - width helpers DATA_W (data/bias) and WEIGHT_W (weights)
//   - cnt_width(): element counter width, $clog2(n) with a minimum of 1
//   - loader_state_t: loader sequencing states
package neuron_pkg;

   localparam int unsigned DEF_N  = 2;
   localparam int unsigned DEF_QM = 3;
   localparam int unsigned DEF_QN = 5;
   localparam int unsigned DEF_WM = 6;
   localparam int unsigned DEF_WN = 10;

   localparam int unsigned DATA_W   = DEF_QM + DEF_QN;
   localparam int unsigned WEIGHT_W = DEF_WM + DEF_WN;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned CNT_W = cnt_width(DEF_N);

   typedef enum logic [1:0] {
      FILL,
      SETTLE,
      CAPTURE
   } loader_state_t;

endpackage

// File: rtl/result_slot.sv
// Single-entry valid/ready output register.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        write load_data into the slot (takes priority over a drain)
//   load_data   value to store
//   ready       downstream consumer ready
//   valid       slot holds a result
//   data        stored result, stable while valid && !ready
//   free        slot can accept a load this cycle (empty, or draining now)
module result_slot #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         free
);

   assign free = !valid || ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/neuron_input_loader.sv
// Serial-to-parallel feeder for the fully parallel neuron.
//
// Accepts (input, weight) element pairs one per cycle, assembles them into
// N-wide registered vectors plus bias for the neuron, waits for the neuron's
// registered output and hands each result downstream over valid/ready.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   s_valid/s_ready     element stream handshake
//   s_data, s_weight    element pair
//   s_last              end-of-vector marker (checked only with the macro)
//   bias_in             bias, sampled with element 0
//   nv_in, nv_weights   registered vectors to the neuron
//   nv_bias             registered bias to the neuron
//   nv_out              neuron registered output
//   m_valid/m_ready     result stream handshake
//   m_data              result
//   err                 sticky framing error
//
// Build option: NEURON_LOADER_LAST_CHECK_EN enables s_last framing checks and
// the sticky err flag; without it s_last is ignored and err is tied 0.
module neuron_input_loader
   import neuron_pkg::*;
#(
   parameter int unsigned N  = DEF_N,
   parameter int unsigned QM = DEF_QM,
   parameter int unsigned QN = DEF_QN,
   parameter int unsigned WM = DEF_WM,
   parameter int unsigned WN = DEF_WN
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic signed [QM+QN-1:0]         s_data,
   input  logic signed [WM+WN-1:0]         s_weight,
   input  logic                            s_last,
   input  logic signed [QM+QN-1:0]         bias_in,
   output logic [N-1:0][QM+QN-1:0]         nv_in,
   output logic [N-1:0][WM+WN-1:0]         nv_weights,
   output logic signed [QM+QN-1:0]         nv_bias,
   input  logic [QM+QN-1:0]                nv_out,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [QM+QN-1:0]                m_data,
   output logic                            err
);

   localparam int unsigned DW = QM + QN;
   localparam int unsigned CW = cnt_width(N);
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   loader_state_t  state, state_d;
   logic [CW-1:0]  count, count_d;
   logic           wr_en;
   logic           load;
   logic           slot_free;

`ifdef NEURON_LOADER_LAST_CHECK_EN
   logic           err_flag, err_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
         count <= '0;
      end else begin
         state <= state_d;
         count <= count_d;
      end
   end

   // Vector registers change only on an accepted element in FILL, so the
   // neuron sees stable operands through SETTLE and CAPTURE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nv_in      <= '0;
         nv_weights <= '0;
         nv_bias    <= '0;
      end else if (wr_en) begin
         nv_in[count]      <= s_data;
         nv_weights[count] <= s_weight;
         if (count == '0) begin
            nv_bias <= bias_in;
         end
      end
   end

   always_comb begin
      state_d = state;
      count_d = count;
      s_ready = 1'b0;
      wr_en   = 1'b0;
      load    = 1'b0;
`ifdef NEURON_LOADER_LAST_CHECK_EN
      err_d   = err_flag;
`endif
      unique case (state)
         FILL: begin
            s_ready = 1'b1;
            if (s_valid) begin
`ifdef NEURON_LOADER_LAST_CHECK_EN
               // Early s_last: drop the partial vector and restart framing.
               if (s_last && (count != LAST_IDX)) begin
                  count_d = '0;
                  err_d   = 1'b1;
               end else
`endif
               begin
                  wr_en = 1'b1;
                  if (count == LAST_IDX) begin
                     count_d = '0;
                     state_d = SETTLE;
`ifdef NEURON_LOADER_LAST_CHECK_EN
                     if (!s_last) begin
                        err_d = 1'b1;
                     end
`endif
                  end else begin
                     count_d = count + CNT_ONE;
                  end
               end
            end
         end
         // Neuron combinational path settles; its output register captures
         // at the end of this cycle.
         SETTLE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            if (slot_free) begin
               load    = 1'b1;
               state_d = FILL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

`ifdef NEURON_LOADER_LAST_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_flag <= 1'b0;
      end else begin
         err_flag <= err_d;
      end
   end

   assign err = err_flag;
`else
   logic unused_last;
   assign unused_last = s_last;
   assign err         = 1'b0;
`endif

   result_slot #(
      .W (DW)
   ) u_result_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (nv_out),
      .ready     (m_ready),
      .valid     (m_valid),
      .data      (m_data),
      .free      (slot_free)
   );

endmodule

// File: doc/neuron_input_loader.md
# neuron_input_loader

Upstream feeder for the fully parallel neuron. It accepts (input, weight) element pairs one per cycle over a valid/ready stream and assembles them into the N-wide input/weight vectors plus bias that drive the neuron. It sequences the neuron's one-cycle registered output and hands each result downstream over a valid/ready stream. This lets a narrow serial source drive the parallel neuron without holding all N operands itself.

## Interface
- N, 2, elements per vector (neuron fan-in)
- QM, 3, integer bits of data/bias (signed Q format)
- QN, 5, fraction bits of data/bias
- WM, 6, integer bits of weights
- WN, 10, fraction bits of weights

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  element valid
- s_ready  out  1  element accepted when s_valid && s_ready
- s_data  in  QM+QN signed  input element
- s_weight  in  WM+WN signed  weight element
- s_last  in  1  marks final element of a vector (used only under macro)
- bias_in  in  QM+QN signed  bias, sampled with element 0
- nv_in  out  [N-1:0] x QM+QN signed  input vector to neuron
- nv_weights  out  [N-1:0] x WM+WN signed  weight vector to neuron
- nv_bias  out  QM+QN signed  bias to neuron
- nv_out  in  QM+QN  neuron registered output
- m_valid  out  1  result valid
- m_ready  in  1  result consumed when m_valid && m_ready
- m_data  out  QM+QN  result
- err  out  1  sticky framing error (tied 0 without macro)

## Operation
- States: FILL, SETTLE, CAPTURE.
- FILL: s_ready=1. Each accepted element at count c is written to nv_in[c] and nv_weights[c]. At c=0, bias_in is also written to nv_bias. Count increments.
- When the element at c=N-1 is accepted, count wraps to 0 and the state goes to SETTLE.
- SETTLE: lasts one cycle, s_ready=0. The vectors are stable and the neuron's combinational path settles. The neuron output register captures at the end of this cycle. Next state is CAPTURE.
- CAPTURE: s_ready=0, and nv_out is valid for the current vector.
  - If the slot is free (!m_valid, or m_valid && m_ready this cycle): m_data<=nv_out, m_valid<=1, next state FILL.
  - Otherwise: stay in CAPTURE and hold the vectors.
- Result slot rules:
  - m_valid clears on a handshake unless it is reloaded on the same edge.
  - m_data is stable while m_valid && !m_ready.
- Filling of the next vector overlaps with a pending result. The vector registers are rewritten only in FILL.
- nv_* outputs stay registered; there is no combinational path from s_* to nv_*.
- Widths pass through unchanged. The block performs no arithmetic on data.

## Timing
- Reset values:
  - state FILL, count 0
  - nv_in, nv_weights and nv_bias all 0
  - m_valid 0, m_data 0, err 0
  - s_ready 1 one cycle after reset deassertion is seen (s_ready=1 in FILL)
- Latency: last element accepted on edge E0, SETTLE during E0→E1, CAPTURE during E1→E2, m_valid=1 after E2. That is 2 cycles when the slot is free.
- Throughput: one vector per N+2 cycles with continuous s_valid and m_ready.
- Reset mid-vector: the partial vector is discarded and any pending result is dropped.
- s_valid low in FILL: the count holds and nothing is written.

## Configuration
- NEURON_LOADER_LAST_CHECK_EN defined:
  - s_last is checked on every accepted element.
  - s_last=1 at c<N-1: the partial vector is discarded, count resets to 0, err is set, and the state stays in FILL.
  - s_last=0 at c=N-1: the vector is still issued and err is set.
  - err stays set until reset.
- Not defined: s_last is ignored and err is constant 0.

## Structure
- A shared package neuron_pkg holds:
  - the loader_state_t enum {FILL, SETTLE, CAPTURE}
  - width helper localparams (DATA_W=QM+QN, WEIGHT_W=WM+WN)
  - a count width of $clog2(N), minimum 1
- One sub-module, result_slot: a single-entry valid/ready output register with load and hold logic.

## Test plan
All scenarios use defaults: N=2, Q3.5 data, Q6.10 weights, with the loader connected to the neuron in the bench.
- Elements (0x20, 0x0400) then (0x40, 0x0400), bias 0x00 → m_data=0x60 (3.0); m_valid rises 2 cycles after the last accept.
- Elements (0x20, 0xFC00) then (0x20, 0x0000), bias 0x00 → neuron sum -1.0 → m_data=0x00 (ReLU).
- Elements (0x7F, 0x7FFF) ×2, bias 0x7F → saturated m_data=0x7F.
- m_ready held 0 for 10 cycles while a second vector fills → the loader sits in CAPTURE with s_ready=0 and m_data held. When m_ready rises, result 1 drains and result 2 loads on the same edge.
- rst_n pulsed low after one element → no m_valid. The next 2 elements form a clean vector: (0x20, 0x0400) ×2, bias 0x20 → m_data=0x60.
- With NEURON_LOADER_LAST_CHECK_EN, s_last=1 on element 0 → err=1 and count resets. The following 2-element vector still yields the correct result.
